// File: rtl/riscv_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : riscv_mem_pkg
// Description : Shared types, widths and the request error check for the
//               data-memory responder.
// Revision    : 1.0 - initial release
// ============================================================================
package riscv_mem_pkg;

    localparam int WORD_W = 32;
    localparam int BE_W   = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    // The whole word index is compared, so addresses beyond the array never wrap.
    function automatic logic req_error(input logic [31:0] addr,
                                       input int unsigned depth_words);
        logic [31:0] w_index;
        w_index = {2'b00, addr[31:2]};
        return (addr[1:0] != 2'b00) || (w_index >= depth_words);
    endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_array.sv
`default_nettype none
// ============================================================================
// Module      : dmem_array
// Description : Word-organised storage with a synchronous byte-enabled write
//               port and a combinational read port. Contents are not reset.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_array
    import riscv_mem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 128,
    parameter int unsigned AW          = 7
) (
    input  logic              clk,
    input  logic              i_wr_en,
    input  logic [AW-1:0]     i_wr_idx,
    input  logic [WORD_W-1:0] i_wr_data,
    input  logic [BE_W-1:0]   i_wr_be,
    input  logic [AW-1:0]     i_rd_idx,
    output logic [WORD_W-1:0] o_rd_data
);

    logic [WORD_W-1:0] r_mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            for (int b = 0; b < BE_W; b++) begin
                if (i_wr_be[b]) begin
                    r_mem[i_wr_idx][8*b +: 8] <= i_wr_data[8*b +: 8];
                end
            end
        end
    end

    assign o_rd_data = r_mem[i_rd_idx];

endmodule
`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
// Module      : dmem_responder
// Description : Handshaked data-memory slave with a fixed, configurable
//               response latency; one response per accepted request.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_responder
    import riscv_mem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 128,
    parameter int unsigned LATENCY     = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [31:0]       req_addr,
    input  logic [WORD_W-1:0] req_wdata,
    input  logic [BE_W-1:0]   req_be,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [WORD_W-1:0] rsp_rdata,
    output logic              rsp_err
);

    localparam int unsigned c_AW       = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [3:0]  c_CNT_INIT = 4'(LATENCY - 1);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [3:0]        r_cnt;
    logic [3:0]        w_cnt_nxt;
    logic              w_accept;
    logic              w_enter_resp;

    logic              r_we;
    logic [31:0]       r_addr;
    logic [WORD_W-1:0] r_wdata;
    logic [BE_W-1:0]   r_be;
    logic [WORD_W-1:0] r_rdata;
    logic              r_err;

    logic              w_cur_we;
    logic [31:0]       w_cur_addr;
    logic [WORD_W-1:0] w_cur_wdata;
    logic [BE_W-1:0]   w_cur_be;
    logic              w_cur_err;
    logic              w_arr_we;
    logic [WORD_W-1:0] w_arr_rdata;

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_accept     = 1'b0;
        w_enter_resp = 1'b0;
        case (r_state)
            IDLE: begin
                if (req_valid) begin
                    w_accept  = 1'b1;
                    w_cnt_nxt = c_CNT_INIT;
                    if (LATENCY > 1) begin
                        w_state_nxt = WAIT;
                    end else begin
                        w_state_nxt  = RESP;
                        w_enter_resp = 1'b1;
                    end
                end
            end
            WAIT: begin
                w_cnt_nxt = r_cnt - 4'd1;
                if (r_cnt == 4'd1) begin
                    w_state_nxt  = RESP;
                    w_enter_resp = 1'b1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // With single-cycle latency the commit edge is the accept edge, so the
    // live request is used instead of the not-yet-latched copy.
    assign w_cur_we    = (r_state == IDLE) ? req_we    : r_we;
    assign w_cur_addr  = (r_state == IDLE) ? req_addr  : r_addr;
    assign w_cur_wdata = (r_state == IDLE) ? req_wdata : r_wdata;
    assign w_cur_be    = (r_state == IDLE) ? req_be    : r_be;
    assign w_cur_err   = req_error(w_cur_addr, DEPTH_WORDS);
    assign w_arr_we    = w_enter_resp & w_cur_we & ~w_cur_err & ~reset;

    dmem_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .AW          (c_AW)
    ) u_array (
        .clk       (clk),
        .i_wr_en   (w_arr_we),
        .i_wr_idx  (w_cur_addr[c_AW+1:2]),
        .i_wr_data (w_cur_wdata),
        .i_wr_be   (w_cur_be),
        .i_rd_idx  (w_cur_addr[c_AW+1:2]),
        .o_rd_data (w_arr_rdata)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_be    <= '0;
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_we    <= req_we;
                r_addr  <= req_addr;
                r_wdata <= req_wdata;
                r_be    <= req_be;
            end
            if (w_enter_resp) begin
                r_rdata <= (w_cur_we || w_cur_err) ? '0 : w_arr_rdata;
                r_err   <= w_cur_err;
            end
        end
    end

    assign req_ready = (r_state == IDLE) & ~reset;
    assign rsp_valid = (r_state == RESP);
    assign rsp_rdata = r_rdata;
    assign rsp_err   = r_err;

endmodule
`default_nettype wire
